// File: rtl/snitch_vfpr_pkg.sv
// Shared types and constants for the vector FP register file request arbiter.
package snitch_vfpr_pkg;

  // Default number of requesters sharing the VFPR write port
  localparam int unsigned NumVfprReq = 3;

  // Requester slot assignment
  localparam int unsigned VfprReqFpu = 0;
  localparam int unsigned VfprReqSsr = 1;
  localparam int unsigned VfprReqLsu = 2;

  // Port geometry of the VFPR TCDM-style interface
  localparam int unsigned VfprAddrWidth = 5;
  localparam int unsigned VfprDataWidth = 64;
  localparam int unsigned VfprStrbWidth = VfprDataWidth / 8;
  localparam int unsigned VfprUserWidth = 4;

  typedef struct packed {
    logic [VfprAddrWidth-1:0] addr;
    logic                     write;
    logic [VfprDataWidth-1:0] data;
    logic [VfprStrbWidth-1:0] strb;
    logic [VfprUserWidth-1:0] user;
  } vfpr_tcdm_q_t;

  typedef struct packed {
    logic         q_valid;
    vfpr_tcdm_q_t q;
  } vfpr_tcdm_req_t;

  typedef struct packed {
    logic [VfprDataWidth-1:0] data;
  } vfpr_tcdm_p_t;

  typedef struct packed {
    logic         q_ready;
    logic         p_valid;
    vfpr_tcdm_p_t p;
  } vfpr_tcdm_rsp_t;

endpackage

// File: rtl/snitch_vfpr_id_fifo.sv
// Requester-ID FIFO: remembers who owns each in-flight transaction.
// Registered head, no fall-through; pushes when full and pops when empty are ignored.
module snitch_vfpr_id_fifo #(
  parameter  int unsigned Width = 2,
  parameter  int unsigned Depth = 4,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  usage_q, usage_d;
  logic             do_push, do_pop;

  assign full_o  = (usage_q == CntW'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and fill level, wrapping at Depth (need not be a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   usage_d = usage_q + CntW'(1);
      2'b01:   usage_d = usage_q - CntW'(1);
      default: usage_d = usage_q;
    endcase
  end

  // Pointer and fill-level registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/snitch_vfpr_arbiter.sv
// Round-robin arbiter sharing the VFPR request port between NumReq requesters.
// Grants lock while a request stalls; in-order responses are routed back by ID.
module snitch_vfpr_arbiter
  import snitch_vfpr_pkg::*;
#(
  parameter  int unsigned NumReq         = NumVfprReq,
  parameter  int unsigned MaxOutstanding = 4,
  parameter  type         tcdm_req_t     = vfpr_tcdm_req_t,
  parameter  type         tcdm_rsp_t     = vfpr_tcdm_rsp_t,
  localparam int unsigned IdWidth        = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  tcdm_req_t [NumReq-1:0] req_i,
  output tcdm_rsp_t [NumReq-1:0] rsp_o,
  output tcdm_req_t              vfpr_req_o,
  input  tcdm_rsp_t              vfpr_rsp_i,
  output logic [CntW-1:0]        outstanding_o
);

  logic [IdWidth-1:0] rr_q, rr_d;
  logic               lock_q, lock_d;
  logic [IdWidth-1:0] lock_id_q, lock_id_d;

  logic [IdWidth-1:0] win_id;
  logic               win_valid;
  logic               gnt_ok, hs, pop;
  logic               fifo_full, fifo_empty;
  logic [IdWidth-1:0] head_id;

  // Winner pick: a locked requester keeps the grant; otherwise first valid at/after rr_q
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_id    = lock_id_q;
    win_valid = 1'b0;
    if (lock_q) begin
      // A dropped valid leaves no winner this cycle; the lock then clears
      win_valid = req_i[lock_id_q].q_valid;
    end else begin
      win_id = '0;
      for (int k = 0; k < NumReq; k++) begin
        cand = (int'(rr_q) + k) % NumReq;
        if (!win_valid && req_i[cand].q_valid) begin
          win_valid = 1'b1;
          win_id    = IdWidth'(cand);
        end
      end
    end
  end

  // A full ID FIFO blocks the grant outright, even when a response pops in the same cycle
  assign gnt_ok = win_valid & ~fifo_full & ~rst_i;
  assign hs     = gnt_ok & vfpr_rsp_i.q_ready;
  assign pop    = vfpr_rsp_i.p_valid & ~fifo_empty & ~rst_i;

  // Pointer and lock next-state; the lock also holds across a full-FIFO stall so q stays put
  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (hs) begin
      rr_d   = (win_id == IdWidth'(NumReq - 1)) ? '0 : win_id + IdWidth'(1);
      lock_d = 1'b0;
    end else if (win_valid) begin
      lock_d    = 1'b1;
      lock_id_d = win_id;
    end else begin
      lock_d = 1'b0;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  snitch_vfpr_id_fifo #(
    .Width (IdWidth),
    .Depth (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (win_id),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (outstanding_o)
  );

  // Downstream request: winner's q fields pass through untouched
  always_comb begin
    vfpr_req_o         = req_i[win_id];
    vfpr_req_o.q_valid = gnt_ok;
  end

  // Upstream responses: ready to the winner only, response data to the FIFO head only
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rsp_o[i]         = '0;
      rsp_o[i].p.data  = vfpr_rsp_i.p.data;
      rsp_o[i].q_ready = hs && (win_id == IdWidth'(i));
      rsp_o[i].p_valid = pop && (head_id == IdWidth'(i));
    end
  end

  // Protocol monitors: both conditions are tolerated by the logic but flag a misbehaving neighbour
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_no_orphan: assert (!(vfpr_rsp_i.p_valid && fifo_empty))
        else $warning("vfpr_arbiter: orphan response dropped");
      a_hold_valid: assert (!(lock_q && !req_i[lock_id_q].q_valid))
        else $warning("vfpr_arbiter: requester %0d dropped q_valid before ready", lock_id_q);
    end
  end

endmodule
